// File: rtl/seg_pkg.sv
// Shared glyph codes and 7-segment patterns for the lock's display path.
// All patterns are stored active-low, bit order [6:0] = {a,b,c,d,e,f,g}, so 0 = lit.
`timescale 1ns/1ps

package seg_pkg;

  // Character codes. Bit 4 clear selects a hex nibble; bit 4 set selects a special glyph.
  localparam logic [4:0] CODE_P    = 5'b10000;
  localparam logic [4:0] CODE_U    = 5'b10001;
  localparam logic [4:0] CODE_R    = 5'b10010;
  localparam logic [4:0] CODE_L    = 5'b11100;
  localparam logic [4:0] CODE_N    = 5'b11110;
  localparam logic [4:0] CODE_DASH = 5'b11111;

  // Hex glyphs, active-low.
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  // Lock-specific glyphs, active-low.
  localparam logic [6:0] SEG_P     = 7'b0011000;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_R     = 7'b1111010;
  localparam logic [6:0] SEG_L     = 7'b1110001;
  localparam logic [6:0] SEG_N     = 7'b1101010;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Hex nibble to active-low glyph.
  function automatic logic [6:0] seg_hex(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = SEG_0;
      4'h1:    pat = SEG_1;
      4'h2:    pat = SEG_2;
      4'h3:    pat = SEG_3;
      4'h4:    pat = SEG_4;
      4'h5:    pat = SEG_5;
      4'h6:    pat = SEG_6;
      4'h7:    pat = SEG_7;
      4'h8:    pat = SEG_8;
      4'h9:    pat = SEG_9;
      4'hA:    pat = SEG_A;
      4'hB:    pat = SEG_B;
      4'hC:    pat = SEG_C;
      4'hD:    pat = SEG_D;
      4'hE:    pat = SEG_E;
      4'hF:    pat = SEG_F;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  // Special code to active-low glyph; unassigned codes stay blank.
  function automatic logic [6:0] seg_special(input logic [4:0] code);
    logic [6:0] pat;
    case (code)
      CODE_P:    pat = SEG_P;
      CODE_U:    pat = SEG_U;
      CODE_R:    pat = SEG_R;
      CODE_L:    pat = SEG_L;
      CODE_N:    pat = SEG_N;
      CODE_DASH: pat = SEG_DASH;
      default:   pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/binary_to_seg.sv
// Registered 5-bit character code to 7-segment decoder for the lock's 4-digit display.
// Output polarity is selected by SEG_ACTIVE_HIGH_EN: undefined gives active-low
// cathodes (reset 1111111); defined inverts every pattern (reset 0000000, still dark).
`timescale 1ns/1ps

module binary_to_seg
  import seg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] seven_in,
  output logic [6:0] seven_out
);

`ifdef SEG_ACTIVE_HIGH_EN
  localparam logic [6:0] SegDark = 7'b0000000;
`else
  localparam logic [6:0] SegDark = SEG_BLANK;
`endif

  logic [6:0] glyph;
  logic [6:0] seg_d;
  logic [6:0] seg_q;

  // Decode the code to an active-low glyph; unknown or unassigned codes blank the digit.
  always_comb begin
    glyph = SEG_BLANK;
    case (seven_in[4])
      1'b0:    glyph = seg_hex(seven_in[3:0]);
      1'b1:    glyph = seg_special(seven_in);
      default: glyph = SEG_BLANK;
    endcase
  end

  // Apply output polarity ahead of the register so the flop drives the pins directly.
  always_comb begin
`ifdef SEG_ACTIVE_HIGH_EN
    seg_d = ~glyph;
`else
    seg_d = glyph;
`endif
  end

  // Output register; reset forces all segments dark immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q <= SegDark;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign seven_out = seg_q;

endmodule

// File: tb/tb_binary_to_seg.sv
// Self-checking bench for binary_to_seg: vector table, reset/latency sequences and
// random codes against a table-lookup reference model. Honours SEG_ACTIVE_HIGH_EN.
`timescale 1ns/1ps

module tb_binary_to_seg;

  logic       clk;
  logic       reset;
  logic [4:0] seven_in;
  logic [6:0] seven_out;

  int checks = 0;
  int errors = 0;

  binary_to_seg dut (
    .clk       (clk),
    .reset     (reset),
    .seven_in  (seven_in),
    .seven_out (seven_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference glyph table, active-low, indexed by the full 5-bit code.
  logic [6:0] ref_tab [32];

  initial begin
    for (int i = 0; i < 32; i++) ref_tab[i] = 7'b1111111;
    ref_tab[0]  = 7'b0000001; ref_tab[1]  = 7'b1001111; ref_tab[2]  = 7'b0010010;
    ref_tab[3]  = 7'b0000110; ref_tab[4]  = 7'b1001100; ref_tab[5]  = 7'b0100100;
    ref_tab[6]  = 7'b0100000; ref_tab[7]  = 7'b0001111; ref_tab[8]  = 7'b0000000;
    ref_tab[9]  = 7'b0000100; ref_tab[10] = 7'b0001000; ref_tab[11] = 7'b1100000;
    ref_tab[12] = 7'b0110001; ref_tab[13] = 7'b1000010; ref_tab[14] = 7'b0110000;
    ref_tab[15] = 7'b0111000;
    ref_tab[16] = 7'b0011000; // P
    ref_tab[17] = 7'b1000001; // U
    ref_tab[18] = 7'b1111010; // r
    ref_tab[28] = 7'b1110001; // L
    ref_tab[30] = 7'b1101010; // n
    ref_tab[31] = 7'b1111110; // -
  end

  function automatic logic [6:0] pol(input logic [6:0] low);
`ifdef SEG_ACTIVE_HIGH_EN
    return ~low;
`else
    return low;
`endif
  endfunction

  function automatic logic [6:0] model(input logic [4:0] code);
    return pol(ref_tab[code]);
  endfunction

  function automatic logic [6:0] dark();
    return pol(7'b1111111);
  endfunction

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Apply one code mid-cycle and compare just after the following rising edge.
  task automatic step(input string name, input logic [4:0] code, input logic [6:0] exp);
    @(negedge clk);
    seven_in = code;
    @(posedge clk);
    #1;
    check(name, seven_out, exp);
  endtask

  typedef struct {
    logic [4:0] code;
    logic [6:0] exp_low;
    string      name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000ns");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] prev;
    logic [4:0] code;

    // Literal vectors straight from the glyph tables.
    vecs.push_back('{5'h00, 7'b0000001, "hex0"});
    vecs.push_back('{5'h01, 7'b1001111, "hex1"});
    vecs.push_back('{5'h02, 7'b0010010, "hex2"});
    vecs.push_back('{5'h03, 7'b0000110, "hex3"});
    vecs.push_back('{5'h04, 7'b1001100, "hex4"});
    vecs.push_back('{5'h05, 7'b0100100, "hex5"});
    vecs.push_back('{5'h06, 7'b0100000, "hex6"});
    vecs.push_back('{5'h07, 7'b0001111, "hex7"});
    vecs.push_back('{5'h08, 7'b0000000, "hex8"});
    vecs.push_back('{5'h09, 7'b0000100, "hex9"});
    vecs.push_back('{5'h0A, 7'b0001000, "hexA"});
    vecs.push_back('{5'h0B, 7'b1100000, "hexb"});
    vecs.push_back('{5'h0C, 7'b0110001, "hexC"});
    vecs.push_back('{5'h0D, 7'b1000010, "hexd"});
    vecs.push_back('{5'h0E, 7'b0110000, "hexE"});
    vecs.push_back('{5'h0F, 7'b0111000, "hexF"});
    vecs.push_back('{5'b10000, 7'b0011000, "spec_P"});
    vecs.push_back('{5'b10001, 7'b1000001, "spec_U"});
    vecs.push_back('{5'b10010, 7'b1111010, "spec_r"});
    vecs.push_back('{5'b11100, 7'b1110001, "spec_L"});
    vecs.push_back('{5'b11110, 7'b1101010, "spec_n"});
    vecs.push_back('{5'b11111, 7'b1111110, "spec_dash"});
    vecs.push_back('{5'b10101, 7'b1111111, "undef_10101"});
    vecs.push_back('{5'b10011, 7'b1111111, "undef_10011"});
    vecs.push_back('{5'b11011, 7'b1111111, "undef_11011"});
    vecs.push_back('{5'b11101, 7'b1111111, "undef_11101"});

    // Power-on reset: dark before any clock edge.
    reset    = 1'b1;
    seven_in = 5'b01000;
    #1;
    check("reset_initial", seven_out, dark());
    @(posedge clk);
    #1;
    check("reset_hold_initial", seven_out, dark());
    @(negedge clk);
    reset = 1'b0;

    // Table sweep, one code per cycle.
    foreach (vecs[i]) step(vecs[i].name, vecs[i].code, pol(vecs[i].exp_low));

    // Lock code words.
    step("CLSd_C", 5'b01100, model(5'b01100));
    step("CLSd_L", 5'b11100, model(5'b11100));
    step("CLSd_S", 5'b00101, model(5'b00101));
    step("CLSd_d", 5'b01101, model(5'b01101));
    step("OPEn_O", 5'b00000, model(5'b00000));
    step("OPEn_P", 5'b10000, model(5'b10000));
    step("OPEn_E", 5'b01110, model(5'b01110));
    step("OPEn_n", 5'b11110, model(5'b11110));

    // Latency: output holds the old glyph until the edge, then shows the new one.
    prev = 5'b11110;
    for (int i = 0; i < 8; i++) begin
      code = (i % 2 == 0) ? 5'b00001 : 5'b00010;
      @(negedge clk);
      check("latency_hold", seven_out, model(prev));
      seven_in = code;
      #1;
      check("latency_no_passthru", seven_out, model(prev));
      @(posedge clk);
      #1;
      check("latency_update", seven_out, model(code));
      prev = code;
    end

    // Mid-run asynchronous reset with code 8 on the input.
    @(negedge clk);
    seven_in = 5'b01000;
    #2;
    reset = 1'b1;
    #1;
    check("reset_async", seven_out, dark());
    @(posedge clk);
    #1;
    check("reset_hold_1", seven_out, dark());
    @(posedge clk);
    #1;
    check("reset_hold_2", seven_out, dark());
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_released_no_edge", seven_out, dark());
    @(posedge clk);
    #1;
    check("reset_first_decode", seven_out, model(5'b01000));

    // Random codes against the reference model.
    for (int i = 0; i < 300; i++) begin
      code = 5'($urandom_range(0, 31));
      step("random", code, model(code));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
